// File: rtl/icap_readback.sv
// Reads one configuration register through ICAP_SPARTAN6: sync, read header, poll, capture.
// Latency: start in cycle k -> RD_WAIT in cycle k+10, done in cycle k+12 (k+17 with desync).
// Backpressure: none; start is honoured only in IDLE, ICAP BUSY stretches RD_WAIT up to 32 cycles.
//
// Ports:
//   clk, rst                    ICAP clock (<= 20 MHz), synchronous active-high reset
//   start, reg_sel[1:0]         one-cycle read request; 0 BOOTSTS, 1 GENERAL1, 2 GENERAL2, 3 STAT
//   icap_busy, icap_o[15:0]     BUSY and O from the primitive (pin bit order)
//   icap_ce_n, icap_write_n,    registered CE/WRITE/I towards the primitive (pin bit order)
//   icap_i[15:0]
//   busy, done                  sequence in progress / one-cycle end pulse
//   data[15:0], valid, error    captured value (logical bit order), good capture, timeout
//
// Option: define ICAP_READBACK_DESYNC_EN to append a DESYNC command after the read so the
// configuration logic is released; without it the device is left synced.
module icap_readback (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  reg_sel,
    input  logic        icap_busy,
    input  logic [15:0] icap_o,
    output logic        icap_ce_n,
    output logic        icap_write_n,
    output logic [15:0] icap_i,
    output logic        busy,
    output logic        done,
    output logic [15:0] data,
    output logic        valid,
    output logic        error
);

    typedef enum logic [4:0] {
        IDLE, DUMMY, SYNC1, SYNC2, NOOP1, RDHDR, NOOP2, NOOP3,
        ABORT_W, RD_SWITCH, RD_WAIT, RD_END
`ifdef ICAP_READBACK_DESYNC_EN
        , SW_WR, DS_HDR, DS_CMD, DS_NOOP1, DS_NOOP2
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  sel_q;
    logic [4:0]  wait_cnt;
    logic        capture, timeout;
    logic        ce_n_nxt, write_n_nxt;
    logic [15:0] word_nxt;

    // The ICAP pins carry each byte bit-reversed; the operation is its own inverse.
    function automatic logic [15:0] bitswap(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7-i];
            r[8+i]   = w[15-i];
        end
        return r;
    endfunction

    // Type-1 read headers, one word from the selected register.
    function automatic logic [15:0] rd_header(input logic [1:0] sel);
        logic [15:0] h;
        case (sel)
            2'd0:    h = 16'h2C01;
            2'd1:    h = 16'h2A61;
            2'd2:    h = 16'h2A81;
            default: h = 16'h2901;
        endcase
        return h;
    endfunction

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE:      if (start) state_nxt = DUMMY;
            DUMMY:     state_nxt = SYNC1;
            SYNC1:     state_nxt = SYNC2;
            SYNC2:     state_nxt = NOOP1;
            NOOP1:     state_nxt = RDHDR;
            RDHDR:     state_nxt = NOOP2;
            NOOP2:     state_nxt = NOOP3;
            NOOP3:     state_nxt = ABORT_W;
            ABORT_W:   state_nxt = RD_SWITCH;
            RD_SWITCH: state_nxt = RD_WAIT;
            RD_WAIT: begin
                // A ready word wins over the timeout on the 32nd cycle.
                if (!icap_busy) begin
                    capture   = 1'b1;
                    state_nxt = RD_END;
                end else if (wait_cnt == 5'd31) begin
                    timeout   = 1'b1;
                    state_nxt = RD_END;
                end
            end
`ifdef ICAP_READBACK_DESYNC_EN
            RD_END:    state_nxt = SW_WR;
            SW_WR:     state_nxt = DS_HDR;
            DS_HDR:    state_nxt = DS_CMD;
            DS_CMD:    state_nxt = DS_NOOP1;
            DS_NOOP1:  state_nxt = DS_NOOP2;
            DS_NOOP2:  state_nxt = IDLE;
`else
            RD_END:    state_nxt = IDLE;
`endif
            default:   state_nxt = IDLE;
        endcase
    end

    // Pin values are decoded from the next state and registered, so each state's
    // word is on the pins for exactly the cycle the FSM sits in that state.
    always_comb begin
        ce_n_nxt    = 1'b1;
        write_n_nxt = 1'b1;
        word_nxt    = 16'hFFFF;
        case (state_nxt)
            DUMMY:     begin ce_n_nxt = 1'b0; write_n_nxt = 1'b0; word_nxt = 16'hFFFF;          end
            SYNC1:     begin ce_n_nxt = 1'b0; write_n_nxt = 1'b0; word_nxt = 16'hAA99;          end
            SYNC2:     begin ce_n_nxt = 1'b0; write_n_nxt = 1'b0; word_nxt = 16'h5566;          end
            NOOP1:     begin ce_n_nxt = 1'b0; write_n_nxt = 1'b0; word_nxt = 16'h2000;          end
            RDHDR:     begin ce_n_nxt = 1'b0; write_n_nxt = 1'b0; word_nxt = rd_header(sel_q);  end
            NOOP2:     begin ce_n_nxt = 1'b0; write_n_nxt = 1'b0; word_nxt = 16'h2000;          end
            NOOP3:     begin ce_n_nxt = 1'b0; write_n_nxt = 1'b0; word_nxt = 16'h2000;          end
            // Deselect while still in write mode before turning the port around.
            ABORT_W:   write_n_nxt = 1'b0;
            RD_WAIT:   ce_n_nxt = 1'b0;
`ifdef ICAP_READBACK_DESYNC_EN
            SW_WR:     write_n_nxt = 1'b0;
            DS_HDR:    begin ce_n_nxt = 1'b0; write_n_nxt = 1'b0; word_nxt = 16'h30A1;          end
            DS_CMD:    begin ce_n_nxt = 1'b0; write_n_nxt = 1'b0; word_nxt = 16'h000D;          end
            DS_NOOP1:  begin ce_n_nxt = 1'b0; write_n_nxt = 1'b0; word_nxt = 16'h2000;          end
            DS_NOOP2:  begin ce_n_nxt = 1'b0; write_n_nxt = 1'b0; word_nxt = 16'h2000;          end
`endif
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            icap_ce_n    <= 1'b1;
            icap_write_n <= 1'b1;
            icap_i       <= 16'hFFFF;
            busy         <= 1'b0;
            done         <= 1'b0;
            data         <= 16'h0000;
            valid        <= 1'b0;
            error        <= 1'b0;
            wait_cnt     <= 5'd0;
            sel_q        <= 2'd0;
        end else begin
            state        <= state_nxt;
            icap_ce_n    <= ce_n_nxt;
            icap_write_n <= write_n_nxt;
            icap_i       <= bitswap(word_nxt);
            busy         <= (state_nxt != IDLE);
            done         <= (state != IDLE) && (state_nxt == IDLE);
            wait_cnt     <= (state == RD_WAIT) ? wait_cnt + 5'd1 : 5'd0;
            if (state == IDLE && start) begin
                sel_q <= reg_sel;
                valid <= 1'b0;
                error <= 1'b0;
            end
            if (capture) begin
                data  <= bitswap(icap_o);
                valid <= 1'b1;
            end
            if (timeout) begin
                data  <= 16'hFFFF;
                valid <= 1'b0;
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icap_readback.sv
// Directed bench for icap_readback: pin word sequences, capture, timeout, ignored restarts, reset.
// Latency figures are counted from the cycle in which start is driven high.
// ICAP BUSY is held for a chosen number of RD_WAIT cycles to exercise the poll loop.
module tb_icap_readback;

    logic        clk = 1'b0;
    logic        rst, start, icap_busy;
    logic [1:0]  reg_sel;
    logic [15:0] icap_o;
    logic        icap_ce_n, icap_write_n, busy, done, valid, error;
    logic [15:0] icap_i, data;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] wr_q [$];
    int rdw_cnt, rdw_first, done_cnt, done_cyc;

`ifdef ICAP_READBACK_DESYNC_EN
    localparam int DS_OFF = 5;
`else
    localparam int DS_OFF = 0;
`endif

    icap_readback dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .reg_sel      (reg_sel),
        .icap_busy    (icap_busy),
        .icap_o       (icap_o),
        .icap_ce_n    (icap_ce_n),
        .icap_write_n (icap_write_n),
        .icap_i       (icap_i),
        .busy         (busy),
        .done         (done),
        .data         (data),
        .valid        (valid),
        .error        (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pin monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!icap_ce_n && !icap_write_n) wr_q.push_back(icap_i);
        if (!icap_ce_n && icap_write_n) begin
            rdw_cnt++;
            if (rdw_first < 0) rdw_first = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rdw_cnt   = 0;
        rdw_first = -1;
        done_cnt  = 0;
        done_cyc  = -1;
    endtask

    // hold: number of RD_WAIT cycles during which icap_busy stays high.
    // poke: issue a second start and change reg_sel while the sequence runs.
    task automatic run_seq(input logic [1:0] sel, input int hold, input logic [15:0] o,
                           input bit poke, output int k);
        clear_mon();
        icap_o    = o;
        icap_busy = (hold > 0);
        @(posedge clk); #1;
        k       = cyc;
        start   = 1'b1;
        reg_sel = sel;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("valid_cleared", valid, 1'b0);
        chk("error_cleared", error, 1'b0);
        chk("busy_running", busy, 1'b1);
        for (int i = 0; i < 120 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            if (poke && cyc == k + 3) begin
                start   = 1'b1;
                reg_sel = ~sel;
            end else begin
                start = 1'b0;
            end
            if (rdw_cnt >= hold) icap_busy = 1'b0;
        end
        if (done_cnt == 0) chk("done_timeout", 1'b0, 1'b1);
        icap_busy = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_run(input string t, input int k, input logic [15:0] hdr_pin,
                             input logic [15:0] exp_data, input logic exp_valid,
                             input logic exp_err, input int exp_rdw, input int exp_done);
        logic [15:0] exp_w [$];
        exp_w.push_back(16'hFFFF);
        exp_w.push_back(16'h5599);
        exp_w.push_back(16'hAA66);
        exp_w.push_back(16'h0400);
        exp_w.push_back(hdr_pin);
        exp_w.push_back(16'h0400);
        exp_w.push_back(16'h0400);
`ifdef ICAP_READBACK_DESYNC_EN
        exp_w.push_back(16'h0C85);
        exp_w.push_back(16'h00B0);
        exp_w.push_back(16'h0400);
        exp_w.push_back(16'h0400);
`endif
        chk({t, "_nwords"}, wr_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
            chk($sformatf("%s_word%0d", t, i), wr_q[i], exp_w[i]);
        chk({t, "_rdwait_at"}, rdw_first - k, 10);
        chk({t, "_rdwait_cycles"}, rdw_cnt, exp_rdw);
        chk({t, "_done_at"}, done_cyc - k, exp_done);
        chk({t, "_done_pulses"}, done_cnt, 1);
        chk({t, "_data"}, data, exp_data);
        chk({t, "_valid"}, valid, exp_valid);
        chk({t, "_error"}, error, exp_err);
        chk({t, "_idle_busy"}, busy, 1'b0);
        chk({t, "_idle_ce_n"}, icap_ce_n, 1'b1);
        chk({t, "_idle_i"}, icap_i, 16'hFFFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst       = 1'b1;
        start     = 1'b1;   // must be ignored while in reset
        reg_sel   = 2'd0;
        icap_busy = 1'b0;
        icap_o    = 16'h0000;
        clear_mon();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ce_n", icap_ce_n, 1'b1);
        chk("rst_write_n", icap_write_n, 1'b1);
        chk("rst_icap_i", icap_i, 16'hFFFF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_data", data, 16'h0000);
        chk("rst_valid", valid, 1'b0);
        chk("rst_error", error, 1'b0);
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_writes", wr_q.size(), 0);

        // BOOTSTS, immediate capture: 0x8001 on pins -> 0x0180
        run_seq(2'd0, 0, 16'h8001, 1'b0, k);
        check_run("bootsts", k, 16'h3480, 16'h0180, 1'b1, 1'b0, 1, 12 + DS_OFF);

        // GENERAL1, BUSY never drops: 32-cycle timeout
        run_seq(2'd1, 99, 16'h1234, 1'b0, k);
        check_run("timeout", k, 16'h5486, 16'hFFFF, 1'b0, 1'b1, 32, 43 + DS_OFF);

        // GENERAL1 with a second start and reg_sel change mid-sequence
        run_seq(2'd1, 0, 16'h1234, 1'b1, k);
        check_run("restart", k, 16'h5486, 16'h482C, 1'b1, 1'b0, 1, 12 + DS_OFF);

        // GENERAL2, BUSY drops on the last allowed RD_WAIT cycle
        run_seq(2'd2, 31, 16'h0F01, 1'b0, k);
        check_run("lastcyc", k, 16'h5481, 16'hF080, 1'b1, 1'b0, 32, 43 + DS_OFF);

        // STAT, BUSY for 5 cycles then capture
        run_seq(2'd3, 5, 16'hC003, 1'b0, k);
        check_run("stat", k, 16'h9480, 16'h03C0, 1'b1, 1'b0, 6, 17 + DS_OFF);

        // Reset while polling in RD_WAIT
        clear_mon();
        icap_busy = 1'b1;
        @(posedge clk); #1;
        start   = 1'b1;
        reg_sel = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40 && rdw_cnt < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("rstwait_reached", (rdw_cnt >= 3), 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstwait_ce_n", icap_ce_n, 1'b1);
        chk("rstwait_write_n", icap_write_n, 1'b1);
        chk("rstwait_busy", busy, 1'b0);
        chk("rstwait_valid", valid, 1'b0);
        chk("rstwait_data", data, 16'h0000);
        icap_busy = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("rstwait_no_done", done_cnt, 0);
        chk("rstwait_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icap_readback.md
ICAP_READBACK -- requirements
Module: icap_readback

Interface
REQ-001 clk  in  1  ICAP clock, max 20 MHz; all logic on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 start  in  1  one-cycle request to read one configuration register; sampled only in IDLE.
REQ-004 reg_sel  in  2  register to read: 0 BOOTSTS, 1 GENERAL1, 2 GENERAL2, 3 STAT.
REQ-005 icap_busy  in  1  BUSY from the ICAP_SPARTAN6 primitive.
REQ-006 icap_o  in  16  O data from the ICAP_SPARTAN6 primitive, bit order as on the pins.
REQ-007 icap_ce_n  out  1  ICAP CE, active low; registered.
REQ-008 icap_write_n  out  1  ICAP WRITE (0 = write, 1 = read); registered.
REQ-009 icap_i  out  16  ICAP I data; registered.
REQ-010 busy  out  1  sequence in progress.
REQ-011 done  out  1  one-cycle pulse at end of sequence.
REQ-012 data  out  16  captured register value, normal bit order.
REQ-013 valid  out  1  data holds a good capture; cleared on the next accepted start.
REQ-014 error  out  1  last read timed out; cleared on the next accepted start.

Function
REQ-015 Pin bit order: every 16-bit word is bit-reversed within each byte (bit i <-> bit 7-i, bytes not swapped); this applies to icap_i on output and to icap_o on capture.
REQ-016 Read headers (logical): BOOTSTS 0x2C01, GENERAL1 0x2A61, GENERAL2 0x2A81, STAT 0x2901; reg_sel is latched on the accepted start.
REQ-017 IDLE: icap_ce_n=1, icap_write_n=1, icap_i=0xFFFF, busy=0; a start in IDLE moves to DUMMY on the next edge; start outside IDLE is ignored.
REQ-018 Write phase: one state per cycle, with icap_ce_n=0 and icap_write_n=0; DUMMY 0xFFFF, SYNC1 0xAA99, SYNC2 0x5566, NOOP1 0x2000, RDHDR header, NOOP2 0x2000, NOOP3 0x2000 (logical values).
REQ-019 Each state's word is on the pins during the cycle the FSM is in that state.
REQ-020 ABORT_W: 1 cycle, ce_n=1, write_n=0. RD_SWITCH: 1 cycle, ce_n=1, write_n=1.
REQ-021 RD_WAIT: ce_n=0, write_n=1; a 5-bit counter starts at 0.
REQ-022 In RD_WAIT, icap_busy=0 at an edge: data <= reversed icap_o, valid=1, next state RD_END.
REQ-023 In RD_WAIT, icap_busy=1 on the 32nd RD_WAIT cycle: data=0xFFFF, error=1, valid=0, next state RD_END.
REQ-024 RD_END: 1 cycle, ce_n=1, write_n=1; the next state is per REQ-030/031.
REQ-025 done pulses for exactly 1 cycle, in the first IDLE cycle after the sequence; busy is 1 from DUMMY through the last non-IDLE state.
REQ-026 Latency with start sampled at edge k and icap_busy=0 immediately: RD_WAIT is at k+10 and done is at k+12 without the REQ-030 feature (k+17 with it).

Reset
REQ-027 With rst=1 at an edge: state=IDLE, icap_ce_n=1, icap_write_n=1, icap_i=0xFFFF, busy=0, done=0, data=0x0000, valid=0, error=0, counter=0.
REQ-028 Reset mid-sequence aborts at once with no done pulse; the device may be left synced, which is the caller's concern.
REQ-029 start asserted together with rst is ignored.

Configuration
REQ-030 Macro ICAP_READBACK_DESYNC_EN defined: RD_END -> SW_WR (1 cycle, ce_n=1, write_n=0) -> DS_HDR 0x30A1 -> DS_CMD 0x000D -> DS_NOOP1 0x2000 -> DS_NOOP2 0x2000 (ce_n=0, write_n=0) -> IDLE.
REQ-031 Macro ICAP_READBACK_DESYNC_EN not defined: RD_END -> IDLE; no desync words are issued.

Verification
REQ-032 reg_sel=0, start at k, icap_busy=0, icap_o=0x8001 -> icap_i sequence 0xFFFF, 0x5599, 0xAA66, 0x0400, 0x3480, 0x0400, 0x0400; data=0x0180, valid=1, error=0, done at k+12.
REQ-033 reg_sel=1, icap_busy held 1 -> exactly 32 RD_WAIT cycles with ce_n=0, write_n=1; then data=0xFFFF, error=1, valid=0, one done pulse.
REQ-034 A second start and a reg_sel change during busy -> no effect: a single done, and the header word matches the original reg_sel (pins 0x5486 for GENERAL1).
REQ-035 rst=1 during RD_WAIT -> next cycle ce_n=1, write_n=1, busy=0, valid=0, and no done pulse.
REQ-036 ICAP_READBACK_DESYNC_EN defined -> after RD_END, pins show 0x0C85, 0x00B0, 0x0400, 0x0400; done at k+17. Macro undefined -> done at k+12 and no further writes.
